// File: rtl/lpc_regfile_pkg.sv
// Shared types and constants for the lpc_periph register-file responder.
package lpc_regfile_pkg;

    localparam int          CNT_W         = 4;
    localparam logic [15:0] POSTCODE_ADDR = 16'h0080;

    typedef enum logic [2:0] {
        IDLE,
        WR_WAIT,
        WR_ACK,
        RD_WAIT,
        RD_VALID
    } lpc_state_e;

endpackage

// File: rtl/lpc_regfile_mem.sv
// DEPTH x 8 register array: synchronous write, combinational read, cleared by reset.
module lpc_regfile_mem #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // NOTE: the array is small and flop-based, so it can be cleared by reset;
    // a RAM macro could not be, and would need an explicit clear sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lpc_periph_regfile.sv
// Byte-wide register window behind lpc_periph with programmable response latency.
// Optional POST-code capture at 0x80 is enabled by defining LPC_POSTCODE_EN.
module lpc_periph_regfile
    import lpc_regfile_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h0F00,
    parameter int          DEPTH      = 16,
    parameter int          WR_LATENCY = 2,
    parameter int          RD_LATENCY = 2,
    parameter logic [7:0]  MISS_DATA  = 8'hFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] lpc_addr_i,
    input  logic [7:0]  lpc_data_i,
    input  logic        lpc_data_wr_i,
    output logic        lpc_wr_done_o,
    input  logic        lpc_rd_req_i,
    output logic [7:0]  lpc_data_o,
    output logic        lpc_data_rd_o,
    input  logic        lpc_rd_done_i,
    output logic        hit_o
`ifdef LPC_POSTCODE_EN
    ,
    output logic [7:0]  postcode_o,
    output logic        postcode_stb_o
`endif
);

    localparam int               AW      = $clog2(DEPTH);
    localparam logic [15:0]      DEPTH_W = 16'(DEPTH);
    localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WR_LATENCY);
    localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_LATENCY);

    lpc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             hit_q, hit_d;
    logic             wr_done_q, wr_done_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rdata_q, rdata_d;
`ifdef LPC_POSTCODE_EN
    logic             is_post_q, is_post_d;
    logic [7:0]       postcode_q, postcode_d;
    logic             post_stb_q, post_stb_d;
`endif

    logic [15:0] addr_diff;
    logic        in_window;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    // Unsigned wrap makes addresses below BASE_ADDR huge, so they miss.
    assign addr_diff = lpc_addr_i - BASE_ADDR;
    assign in_window = addr_diff < DEPTH_W;
    assign mem_we    = (state_q == WR_WAIT) && (cnt_q == '0) && hit_q;

    lpc_regfile_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (idx_q),
        .rdata_o (mem_rdata)
    );

    // NOTE: every signal assigned here gets its default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        hit_d      = hit_q;
        wr_done_d  = wr_done_q;
        rd_valid_d = rd_valid_q;
        rdata_d    = rdata_q;
`ifdef LPC_POSTCODE_EN
        is_post_d  = is_post_q;
        postcode_d = postcode_q;
        post_stb_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (lpc_data_wr_i) begin
                    idx_d   = addr_diff[AW-1:0];
                    wdata_d = lpc_data_i;
                    hit_d   = in_window;
                    cnt_d   = WR_CNT;
                    state_d = WR_WAIT;
`ifdef LPC_POSTCODE_EN
                    is_post_d = (lpc_addr_i == POSTCODE_ADDR);
`endif
                end else if (lpc_rd_req_i) begin
                    idx_d   = addr_diff[AW-1:0];
                    hit_d   = in_window;
                    cnt_d   = RD_CNT;
                    state_d = RD_WAIT;
                end
            end
            WR_WAIT: begin
                if (cnt_q == '0) begin
                    wr_done_d = 1'b1;
                    state_d   = WR_ACK;
`ifdef LPC_POSTCODE_EN
                    if (is_post_q) begin
                        postcode_d = wdata_q;
                        post_stb_d = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_ACK: begin
                if (!lpc_data_wr_i) begin
                    wr_done_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d    = hit_q ? mem_rdata : MISS_DATA;
                    rd_valid_d = 1'b1;
                    state_d    = RD_VALID;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_VALID: begin
                // Valid drops on done, but IDLE waits for the request to fall
                // so a request still held high cannot trigger a second read.
                if (!lpc_rd_req_i) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (lpc_rd_done_i) begin
                    rd_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= 8'h00;
            hit_q      <= 1'b0;
            wr_done_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rdata_q    <= 8'h00;
`ifdef LPC_POSTCODE_EN
            is_post_q  <= 1'b0;
            postcode_q <= 8'h00;
            post_stb_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            hit_q      <= hit_d;
            wr_done_q  <= wr_done_d;
            rd_valid_q <= rd_valid_d;
            rdata_q    <= rdata_d;
`ifdef LPC_POSTCODE_EN
            is_post_q  <= is_post_d;
            postcode_q <= postcode_d;
            post_stb_q <= post_stb_d;
`endif
        end
    end

    assign lpc_wr_done_o = wr_done_q;
    assign lpc_data_rd_o = rd_valid_q;
    assign lpc_data_o    = rdata_q;
    assign hit_o         = hit_q;
`ifdef LPC_POSTCODE_EN
    assign postcode_o     = postcode_q;
    assign postcode_stb_o = post_stb_q;
`endif

endmodule

// File: tb/tb_lpc_periph_regfile.sv
// Directed bench for lpc_periph_regfile with default parameters (latencies of 2).
// Define LPC_POSTCODE_EN for both files to exercise the POST-code port.
module tb_lpc_periph_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] lpc_addr_i;
    logic [7:0]  lpc_data_i;
    logic        lpc_data_wr_i;
    logic        lpc_wr_done_o;
    logic        lpc_rd_req_i;
    logic [7:0]  lpc_data_o;
    logic        lpc_data_rd_o;
    logic        lpc_rd_done_i;
    logic        hit_o;
`ifdef LPC_POSTCODE_EN
    logic [7:0]  postcode_o;
    logic        postcode_stb_o;
`endif

    int total = 0;
    int bad   = 0;

    // Latch edge to strobe: LATENCY + 1 edges with the default latency of 2.
    localparam int EXP_LAT = 3;

    lpc_periph_regfile dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .lpc_addr_i    (lpc_addr_i),
        .lpc_data_i    (lpc_data_i),
        .lpc_data_wr_i (lpc_data_wr_i),
        .lpc_wr_done_o (lpc_wr_done_o),
        .lpc_rd_req_i  (lpc_rd_req_i),
        .lpc_data_o    (lpc_data_o),
        .lpc_data_rd_o (lpc_data_rd_o),
        .lpc_rd_done_i (lpc_rd_done_i),
        .hit_o         (hit_o)
`ifdef LPC_POSTCODE_EN
        ,
        .postcode_o     (postcode_o),
        .postcode_stb_o (postcode_stb_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called right after the latch edge; counts edges until the strobe appears.
    task automatic wait_wr(input string tag);
        int n = 0;
        while (lpc_wr_done_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_wr_lat"}, n, EXP_LAT);
    endtask

    task automatic wait_rd(input string tag);
        int n = 0;
        while (lpc_data_rd_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_rd_lat"}, n, EXP_LAT);
    endtask

    task automatic do_write(input string tag, input logic [15:0] addr, input logic [7:0] data,
                            input logic exp_hit);
        lpc_addr_i    = addr;
        lpc_data_i    = data;
        lpc_data_wr_i = 1'b1;
        tick();
        check({tag, "_hit"}, hit_o, exp_hit);
        wait_wr(tag);
        lpc_data_wr_i = 1'b0;
        tick();
        check({tag, "_done_clr"}, lpc_wr_done_o, 1'b0);
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr, input logic [7:0] exp_data,
                           input logic exp_hit);
        lpc_addr_i   = addr;
        lpc_rd_req_i = 1'b1;
        tick();
        check({tag, "_hit"}, hit_o, exp_hit);
        wait_rd(tag);
        check({tag, "_data"}, lpc_data_o, exp_data);
        lpc_rd_done_i = 1'b1;
        lpc_rd_req_i  = 1'b0;
        tick();
        lpc_rd_done_i = 1'b0;
        check({tag, "_valid_clr"}, lpc_data_rd_o, 1'b0);
    endtask

    initial begin
        rst_i         = 1'b1;
        lpc_addr_i    = 16'h0000;
        lpc_data_i    = 8'h00;
        lpc_data_wr_i = 1'b0;
        lpc_rd_req_i  = 1'b0;
        lpc_rd_done_i = 1'b0;
        tick();
        tick();
        check("rst_done", lpc_wr_done_o, 1'b0);
        check("rst_valid", lpc_data_rd_o, 1'b0);
        check("rst_data", lpc_data_o, 8'h00);
        check("rst_hit", hit_o, 1'b0);
`ifdef LPC_POSTCODE_EN
        check("rst_postcode", postcode_o, 8'h00);
        check("rst_post_stb", postcode_stb_o, 1'b0);
`endif
        rst_i = 1'b0;
        tick();

        // Exact write latency: done rises after the third edge past the latch.
        lpc_addr_i    = 16'h0F03;
        lpc_data_i    = 8'h5A;
        lpc_data_wr_i = 1'b1;
        tick();
        check("w5a_hit", hit_o, 1'b1);
        check("w5a_done_n0", lpc_wr_done_o, 1'b0);
        tick();
        check("w5a_done_n1", lpc_wr_done_o, 1'b0);
        tick();
        check("w5a_done_n2", lpc_wr_done_o, 1'b0);
        tick();
        check("w5a_done_n3", lpc_wr_done_o, 1'b1);
        tick();
        check("w5a_done_hold", lpc_wr_done_o, 1'b1);
        lpc_data_wr_i = 1'b0;
        tick();
        check("w5a_done_clr", lpc_wr_done_o, 1'b0);
        do_read("r0f03", 16'h0F03, 8'h5A, 1'b1);

        // Window edges: last entry, first past the end, one below base.
        do_write("w0f0f", 16'h0F0F, 8'hC3, 1'b1);
        do_read("r0f0f", 16'h0F0F, 8'hC3, 1'b1);
        do_read("r0f10", 16'h0F10, 8'hFF, 1'b0);
        do_write("w0f10", 16'h0F10, 8'h77, 1'b0);
        do_read("r0f00_after_miss", 16'h0F00, 8'h00, 1'b1);
        do_read("r0f03_after_miss", 16'h0F03, 8'h5A, 1'b1);
        do_read("r0eff", 16'h0EFF, 8'hFF, 1'b0);

        // Write and read together: write served first, read follows.
        lpc_addr_i    = 16'h0F01;
        lpc_data_i    = 8'h33;
        lpc_data_wr_i = 1'b1;
        lpc_rd_req_i  = 1'b1;
        tick();
        wait_wr("both");
        check("both_no_valid_yet", lpc_data_rd_o, 1'b0);
        lpc_data_wr_i = 1'b0;
        tick();
        check("both_done_clr", lpc_wr_done_o, 1'b0);
        tick();
        wait_rd("both");
        check("both_data", lpc_data_o, 8'h33);

        // Held in RD_VALID without done: output stays put.
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold_data_%0d", i), lpc_data_o, 8'h33);
            check($sformatf("hold_valid_%0d", i), lpc_data_rd_o, 1'b1);
        end
        lpc_rd_done_i = 1'b1;
        tick();
        lpc_rd_done_i = 1'b0;
        check("hold_valid_clr", lpc_data_rd_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("no_repeat_%0d", i), lpc_data_rd_o, 1'b0);
        end
        check("data_retained", lpc_data_o, 8'h33);
        lpc_rd_req_i = 1'b0;
        tick();
        tick();
        check("idle_valid", lpc_data_rd_o, 1'b0);

        // Requests withdrawn right after the latch still complete, one-cycle strobe.
        lpc_addr_i    = 16'h0F02;
        lpc_data_i    = 8'h9C;
        lpc_data_wr_i = 1'b1;
        tick();
        lpc_data_wr_i = 1'b0;
        wait_wr("early_w");
        tick();
        check("early_w_pulse", lpc_wr_done_o, 1'b0);
        lpc_rd_req_i = 1'b1;
        tick();
        lpc_rd_req_i = 1'b0;
        wait_rd("early_r");
        check("early_r_data", lpc_data_o, 8'h9C);
        tick();
        check("early_r_pulse", lpc_data_rd_o, 1'b0);

        // Reset in WR_WAIT aborts the write.
        lpc_addr_i    = 16'h0F00;
        lpc_data_i    = 8'hAA;
        lpc_data_wr_i = 1'b1;
        tick();
        tick();
        rst_i         = 1'b1;
        lpc_data_wr_i = 1'b0;
        tick();
        check("mid_rst_done", lpc_wr_done_o, 1'b0);
        check("mid_rst_valid", lpc_data_rd_o, 1'b0);
        check("mid_rst_data", lpc_data_o, 8'h00);
        check("mid_rst_hit", hit_o, 1'b0);
        rst_i = 1'b0;
        tick();
        do_read("r0f00_after_rst", 16'h0F00, 8'h00, 1'b1);
        do_read("r0f02_after_rst", 16'h0F02, 8'h00, 1'b1);

        // Write to 0x80: always a window miss; captured as POST code when enabled.
        lpc_addr_i    = 16'h0080;
        lpc_data_i    = 8'h42;
        lpc_data_wr_i = 1'b1;
        tick();
        check("pc_hit", hit_o, 1'b0);
        wait_wr("pc");
`ifdef LPC_POSTCODE_EN
        check("pc_value", postcode_o, 8'h42);
        check("pc_stb", postcode_stb_o, 1'b1);
`endif
        lpc_data_wr_i = 1'b0;
        tick();
        check("pc_done_clr", lpc_wr_done_o, 1'b0);
`ifdef LPC_POSTCODE_EN
        check("pc_stb_clr", postcode_stb_o, 1'b0);
        check("pc_value_hold", postcode_o, 8'h42);
`endif
        do_read("r0f00_after_pc", 16'h0F00, 8'h00, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
